// File: rtl/rv_rf_dbg_access.sv
// ---------------------------------------------------------------------------
// rv_rf_dbg_access
//
// Debug-side initiator for the integer register file. Accepts single-register
// read/write and full 32-register dump commands, halts the core through a
// request/acknowledge pair, drives the register-file ports for one cycle per
// access while the top level muxes them away from the core, and returns one
// response per register on a valid/ready channel.
//
// Ports
//   i_da_clk, i_da_rstn        clock, asynchronous active-low reset
//   i_da_req_*, o_da_req_ready command channel (cmd 00 rd, 01 wr, 10 dump, 11 bad)
//   o_da_rsp_*, i_da_rsp_ready response channel (data/addr/err/last)
//   o_da_halt_req, i_da_halted core halt handshake
//   o_da_rf_sel                top-level register-file mux select
//   o_da_rf_ra, i_da_rf_rd     register-file read port (combinational data)
//   o_da_rf_wa/wd/we           register-file write port (write on falling edge)
// ---------------------------------------------------------------------------
`ifndef XLEN
`define XLEN 32
`endif

module rv_rf_dbg_access #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             i_da_clk,
  input  logic             i_da_rstn,
  input  logic             i_da_req_valid,
  output logic             o_da_req_ready,
  input  logic [1:0]       i_da_req_cmd,
  input  logic [4:0]       i_da_req_addr,
  input  logic [`XLEN-1:0] i_da_req_wdata,
  output logic             o_da_rsp_valid,
  input  logic             i_da_rsp_ready,
  output logic [`XLEN-1:0] o_da_rsp_data,
  output logic [4:0]       o_da_rsp_addr,
  output logic             o_da_rsp_err,
  output logic             o_da_rsp_last,
  output logic             o_da_halt_req,
  input  logic             i_da_halted,
  output logic             o_da_rf_sel,
  output logic [4:0]       o_da_rf_ra,
  input  logic [`XLEN-1:0] i_da_rf_rd,
  output logic [4:0]       o_da_rf_wa,
  output logic [`XLEN-1:0] o_da_rf_wd,
  output logic             o_da_rf_we
);

  localparam logic [7:0] TO_LIM = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HALT,
    S_ACCESS,
    S_RESP
  } state_t;

  typedef enum logic [1:0] {
    CMD_READ  = 2'b00,
    CMD_WRITE = 2'b01,
    CMD_DUMP  = 2'b10,
    CMD_ILL   = 2'b11
  } cmd_t;

  state_t           r_state;
  state_t           w_state_nxt;
  cmd_t             r_cmd;
  cmd_t             w_req_cmd;
  logic [4:0]       r_addr;        // latched index, doubles as the dump index
  logic [`XLEN-1:0] r_wdata;
  logic [7:0]       r_cnt;         // cycles spent waiting in HALT
  logic [7:0]       w_cnt_inc;
  logic [`XLEN-1:0] r_rsp_data;
  logic             r_rsp_err;
  logic             r_rsp_last;

  assign w_req_cmd = cmd_t'(i_da_req_cmd);
  assign w_cnt_inc = r_cnt + 8'd1;

  // The response index is the working index itself: it only advances on the
  // response handshake, so it is stable for the whole RESP state.
  assign o_da_rsp_addr = r_addr;
  assign o_da_rsp_data = r_rsp_data;
  assign o_da_rsp_err  = r_rsp_err;
  assign o_da_rsp_last = r_rsp_last;

  // Next state and state-decoded outputs.
  // NOTE: every signal gets a default before the case, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt    = r_state;
    o_da_req_ready = 1'b0;
    o_da_rsp_valid = 1'b0;
    o_da_halt_req  = 1'b0;
    o_da_rf_sel    = 1'b0;
    o_da_rf_ra     = '0;
    o_da_rf_wa     = '0;
    o_da_rf_wd     = '0;
    o_da_rf_we     = 1'b0;

    case (r_state)
      S_IDLE: begin
        o_da_req_ready = 1'b1;
        if (i_da_req_valid) begin
          // An illegal command never disturbs the core.
          w_state_nxt = (w_req_cmd == CMD_ILL) ? S_RESP : S_HALT;
        end
      end

      S_HALT: begin
        o_da_halt_req = 1'b1;
        if (i_da_halted) begin
          w_state_nxt = S_ACCESS;
        end else if (w_cnt_inc == TO_LIM) begin
          w_state_nxt = S_RESP;
        end
      end

      S_ACCESS: begin
        o_da_halt_req = 1'b1;
        o_da_rf_sel   = 1'b1;
        o_da_rf_ra    = r_addr;
        o_da_rf_wa    = r_addr;
        o_da_rf_wd    = r_wdata;
        // x0 is hardwired; the write is dropped but still reported as success.
        o_da_rf_we    = (r_cmd == CMD_WRITE) && (r_addr != 5'd0);
        w_state_nxt   = S_RESP;
      end

      S_RESP: begin
        o_da_rsp_valid = 1'b1;
        // Error responses (timeout, illegal) never hold the core.
        o_da_halt_req  = !r_rsp_err;
        if (i_da_rsp_ready) begin
          w_state_nxt = r_rsp_last ? S_IDLE : S_HALT;
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge i_da_clk or negedge i_da_rstn) begin
    if (!i_da_rstn) begin
      r_state    <= S_IDLE;
      r_cmd      <= CMD_READ;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_cnt      <= '0;
      r_rsp_data <= '0;
      r_rsp_err  <= 1'b0;
      r_rsp_last <= 1'b0;
    end else begin
      r_state <= w_state_nxt;

      case (r_state)
        S_IDLE: begin
          if (i_da_req_valid) begin
            r_cmd      <= w_req_cmd;
            r_addr     <= (w_req_cmd == CMD_DUMP) ? 5'd0 : i_da_req_addr;
            r_wdata    <= i_da_req_wdata;
            r_cnt      <= '0;
            // Pre-load the response as an illegal-command error; every other
            // command overwrites it in HALT (timeout) or ACCESS.
            r_rsp_data <= '0;
            r_rsp_err  <= (w_req_cmd == CMD_ILL);
            r_rsp_last <= 1'b1;
          end
        end

        S_HALT: begin
          if (!i_da_halted) begin
            r_cnt <= w_cnt_inc;
            if (w_cnt_inc == TO_LIM) begin
              r_rsp_data <= '0;
              r_rsp_err  <= 1'b1;
              r_rsp_last <= 1'b1;
            end
          end
        end

        S_ACCESS: begin
          r_rsp_data <= (r_cmd == CMD_WRITE) ? '0 : i_da_rf_rd;
          r_rsp_err  <= 1'b0;
          r_rsp_last <= (r_cmd != CMD_DUMP) || (r_addr == 5'd31);
        end

        S_RESP: begin
          // Next dump entry: advance the index and restart the halt wait.
          if (i_da_rsp_ready && !r_rsp_last) begin
            r_addr <= r_addr + 5'd1;
            r_cnt  <= '0;
          end
        end

        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rv_rf_dbg_access.sv
// ---------------------------------------------------------------------------
// tb_rv_rf_dbg_access
//
// Bench for rv_rf_dbg_access (TIMEOUT = 8). A behavioural register file is
// attached to the rf ports; an independent array of architectural register
// values predicts every response. Latencies are counted as rising edges
// between the accepting edge and the first edge after which rsp_valid is
// visible (normal access 2, illegal command 0, timeout TIMEOUT).
// ---------------------------------------------------------------------------
`ifndef XLEN
`define XLEN 32
`endif

module tb_rv_rf_dbg_access;

  localparam int          XL = `XLEN;
  localparam int unsigned TO = 8;

  logic          clk;
  logic          rstn;
  logic          req_valid;
  logic          req_ready;
  logic [1:0]    req_cmd;
  logic [4:0]    req_addr;
  logic [XL-1:0] req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [XL-1:0] rsp_data;
  logic [4:0]    rsp_addr;
  logic          rsp_err;
  logic          rsp_last;
  logic          halt_req;
  logic          halted;
  logic          rf_sel;
  logic [4:0]    rf_ra;
  logic [XL-1:0] rf_rd;
  logic [4:0]    rf_wa;
  logic [XL-1:0] rf_wd;
  logic          rf_we;

  int n_tests = 0;
  int n_fail  = 0;

  // Environment register file (naive: stores even x0 writes so a bad write
  // enable becomes visible) and expected architectural state.
  logic [XL-1:0] rf_mem   [32];
  logic [XL-1:0] ref_regs [32];

  int we_cnt      = 0;
  int sel_cnt     = 0;
  int halt_cnt    = 0;
  int overlap_cnt = 0;
  int x0_we_cnt   = 0;
  logic [4:0] last_wa = '0;

  rv_rf_dbg_access #(.TIMEOUT(TO)) dut (
    .i_da_clk       (clk),
    .i_da_rstn      (rstn),
    .i_da_req_valid (req_valid),
    .o_da_req_ready (req_ready),
    .i_da_req_cmd   (req_cmd),
    .i_da_req_addr  (req_addr),
    .i_da_req_wdata (req_wdata),
    .o_da_rsp_valid (rsp_valid),
    .i_da_rsp_ready (rsp_ready),
    .o_da_rsp_data  (rsp_data),
    .o_da_rsp_addr  (rsp_addr),
    .o_da_rsp_err   (rsp_err),
    .o_da_rsp_last  (rsp_last),
    .o_da_halt_req  (halt_req),
    .i_da_halted    (halted),
    .o_da_rf_sel    (rf_sel),
    .o_da_rf_ra     (rf_ra),
    .i_da_rf_rd     (rf_rd),
    .o_da_rf_wa     (rf_wa),
    .o_da_rf_wd     (rf_wd),
    .o_da_rf_we     (rf_we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign rf_rd = rf_mem[rf_ra];

  always @(negedge clk) begin
    if (rf_we) begin
      rf_mem[rf_wa] = rf_wd;
      we_cnt++;
      last_wa = rf_wa;
      if (rf_wa == 5'd0) x0_we_cnt++;
    end
    if (rf_sel) sel_cnt++;
    if (halt_req) halt_cnt++;
    if (rf_sel && rsp_valid) overlap_cnt++;
  end

  task automatic check(input string tag, input logic [XL-1:0] obs, input logic [XL-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request and return just after the edge that accepted it.
  task automatic accept_req(input logic [1:0] c, input logic [4:0] a, input logic [XL-1:0] wd);
    int g;
    g = 0;
    req_valid = 1'b1;
    req_cmd   = c;
    req_addr  = a;
    req_wdata = wd;
    while (!req_ready && g < 50) begin
      tick();
      g++;
    end
    check("req_ready_wait", XL'(req_ready), XL'(1));
    tick();
    req_valid = 1'b0;
  endtask

  // One single-response command; rdly cycles of back-pressure before ready.
  task automatic do_cmd(input logic [1:0] c, input logic [4:0] a, input logic [XL-1:0] wd,
                        input int rdly, output logic [XL-1:0] o_d, output logic [4:0] o_a,
                        output logic o_e, output logic o_l, output logic o_h, output int lat);
    logic [XL+6:0] snap;
    int            sel0;
    accept_req(c, a, wd);
    lat = 0;
    while (!rsp_valid && lat < 300) begin
      tick();
      lat++;
    end
    check("rsp_valid_wait", XL'(rsp_valid), XL'(1));
    if (rdly > 0) begin
      snap = {rsp_data, rsp_addr, rsp_err, rsp_last};
      sel0 = sel_cnt;
      repeat (rdly) tick();
      check("rsp_hold", XL'({rsp_data, rsp_addr, rsp_err, rsp_last} != snap), XL'(0));
      check("rsp_hold_no_rf", XL'(sel_cnt - sel0), XL'(0));
    end
    o_d = rsp_data;
    o_a = rsp_addr;
    o_e = rsp_err;
    o_l = rsp_last;
    o_h = halt_req;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  initial begin
    logic [XL-1:0] d;
    logic [4:0]    a;
    logic          e, l, h;
    int            lat, we0, sel0, halt0, n, cyc;
    logic [1:0]    rc;
    logic [4:0]    ra;
    logic [XL-1:0] rwd;
    int            rdly;
    logic [XL-1:0] dd [32];
    logic [4:0]    da [32];
    logic          de [32];
    logic          dl [32];
    logic          h_before;

    for (int i = 0; i < 32; i++) begin
      rf_mem[i]   = '0;
      ref_regs[i] = '0;
    end
    rstn      = 1'b0;
    req_valid = 1'b0;
    req_cmd   = 2'b00;
    req_addr  = '0;
    req_wdata = '0;
    rsp_ready = 1'b0;
    halted    = 1'b1;

    // ---- reset state ----
    tick();
    tick();
    check("rst_ctrl", XL'({rsp_valid, rsp_err, rsp_last, halt_req, rf_sel, rf_we}), XL'(0));
    check("rst_addrs", XL'({rsp_addr, rf_ra, rf_wa}), XL'(0));
    check("rst_data", rsp_data | rf_wd, '0);
    rstn = 1'b1;
    tick();
    check("rst_ready", XL'(req_ready), XL'(1));

    // ---- write x5 then read it back ----
    we0 = we_cnt;
    do_cmd(2'b01, 5'd5, 32'hDEADBEEF, 0, d, a, e, l, h, lat);
    ref_regs[5] = 32'hDEADBEEF;
    check("wr5_lat", XL'(lat), XL'(2));
    check("wr5_err_last", XL'({e, l}), XL'(2'b01));
    check("wr5_data", d, '0);
    check("wr5_we_cycles", XL'(we_cnt - we0), XL'(1));
    check("wr5_wa", XL'(last_wa), XL'(5));
    check("wr5_halt_held", XL'(h), XL'(1));
    tick();
    check("wr5_halt_drop", XL'(halt_req), XL'(0));
    do_cmd(2'b00, 5'd5, '0, 2, d, a, e, l, h, lat);
    check("rd5_lat", XL'(lat), XL'(2));
    check("rd5_data", d, ref_regs[5]);
    check("rd5_addr", XL'(a), XL'(5));

    // ---- write to x0 is dropped ----
    we0 = we_cnt;
    do_cmd(2'b01, 5'd0, 32'hFFFFFFFF, 0, d, a, e, l, h, lat);
    check("wr0_err", XL'(e), XL'(0));
    check("wr0_no_we", XL'(we_cnt - we0), XL'(0));
    do_cmd(2'b00, 5'd0, '0, 0, d, a, e, l, h, lat);
    check("rd0_data", d, ref_regs[0]);

    // ---- illegal command ----
    halt0 = halt_cnt;
    sel0  = sel_cnt;
    do_cmd(2'b11, 5'd7, '0, 1, d, a, e, l, h, lat);
    check("ill_lat", XL'(lat), XL'(0));
    check("ill_err_last", XL'({e, l}), XL'(2'b11));
    check("ill_data", d, '0);
    check("ill_no_halt", XL'(halt_cnt - halt0), XL'(0));
    check("ill_no_sel", XL'(sel_cnt - sel0), XL'(0));

    // ---- halt timeout ----
    halted = 1'b0;
    sel0   = sel_cnt;
    halt0  = halt_cnt;
    do_cmd(2'b00, 5'd3, '0, 1, d, a, e, l, h, lat);
    halted = 1'b1;
    check("to_lat", XL'(lat), XL'(TO));
    check("to_err_last", XL'({e, l}), XL'(2'b11));
    check("to_data", d, '0);
    check("to_addr", XL'(a), XL'(3));
    check("to_halt_dropped", XL'(h), XL'(0));
    check("to_halt_cycles", XL'(halt_cnt - halt0), XL'(TO));
    check("to_no_sel", XL'(sel_cnt - sel0), XL'(0));

    // ---- randomized reads/writes/illegal against the reference ----
    for (int k = 0; k < 24; k++) begin
      rc   = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 1));
      ra   = 5'($urandom);
      rwd  = XL'($urandom);
      rdly = int'($urandom_range(0, 3));
      we0  = we_cnt;
      do_cmd(rc, ra, rwd, rdly, d, a, e, l, h, lat);
      if (rc == 2'b11) begin
        check("rnd_ill", XL'({e, l, lat != 0}), XL'(3'b110));
      end else begin
        check("rnd_lat", XL'(lat), XL'(2));
        check("rnd_flags", XL'({e, l, a}), XL'({2'b01, ra}));
        check("rnd_data", d, (rc == 2'b00) ? ref_regs[ra] : '0);
        check("rnd_we", XL'(we_cnt - we0), XL'((rc == 2'b01) && (ra != 5'd0)));
        if (rc == 2'b01 && ra != 5'd0) ref_regs[ra] = rwd;
      end
    end

    // ---- preload x[i] = i*4 ----
    for (int i = 0; i < 32; i++) begin
      rf_mem[i]   = XL'(i * 4);
      ref_regs[i] = XL'(i * 4);
    end

    // ---- dump with toggling ready and two halted-low windows ----
    accept_req(2'b10, 5'd17, '0);
    n        = 0;
    cyc      = 0;
    h_before = 1'b0;
    while (n < 32 && cyc < 2000) begin
      rsp_ready = (cyc % 2 == 1);
      halted    = !((cyc >= 20 && cyc < 26) || (cyc >= 50 && cyc < 56));
      if (rsp_valid && rsp_ready) begin
        dd[n] = rsp_data;
        da[n] = rsp_addr;
        de[n] = rsp_err;
        dl[n] = rsp_last;
        h_before = halt_req;
        n++;
      end
      tick();
      cyc++;
    end
    rsp_ready = 1'b0;
    halted    = 1'b1;
    check("dump_count", XL'(n), XL'(32));
    check("dump_halt_before_last", XL'(h_before), XL'(1));
    check("dump_halt_after_last", XL'(halt_req), XL'(0));
    for (int i = 0; i < n; i++) begin
      check("dump_addr", XL'(da[i]), XL'(i));
      check("dump_data", dd[i], ref_regs[i]);
      check("dump_err_last", XL'({de[i], dl[i]}), XL'({1'b0, i == 31}));
    end

    // ---- dump with ready tied high: 96 edges accept to final handshake ----
    rsp_ready = 1'b1;
    accept_req(2'b10, 5'd0, '0);
    n   = 0;
    cyc = 0;
    while (n < 32 && cyc < 300) begin
      if (rsp_valid) begin
        check("dump2_addr", XL'(rsp_addr), XL'(n));
        n++;
      end
      tick();
      cyc++;
    end
    check("dump2_edges", XL'(cyc), XL'(96));
    check("dump2_idle", XL'({req_ready, halt_req}), XL'(2'b10));

    // ---- async reset during dump entry 10 ----
    accept_req(2'b10, 5'd0, '0);
    cyc = 0;
    while (!(rsp_valid && rsp_addr == 5'd10) && cyc < 300) begin
      tick();
      cyc++;
    end
    check("rst_dump_reach10", XL'(rsp_valid && rsp_addr == 5'd10), XL'(1));
    #2;
    rstn = 1'b0;
    #1;
    check("arst_ctrl", XL'({rsp_valid, rsp_err, rsp_last, halt_req, rf_sel, rf_we}), XL'(0));
    check("arst_addrs", XL'({rsp_addr, rf_ra, rf_wa}), XL'(0));
    check("arst_data", rsp_data | rf_wd, '0);
    rsp_ready = 1'b0;
    tick();
    rstn = 1'b1;
    tick();
    check("arst_ready", XL'(req_ready), XL'(1));
    do_cmd(2'b00, 5'd10, '0, 0, d, a, e, l, h, lat);
    check("arst_rd10", d, ref_regs[10]);
    check("arst_rd10_flags", XL'({e, l, a}), XL'({2'b01, 5'd10}));

    // ---- global invariants ----
    check("no_x0_write", XL'(x0_we_cnt), XL'(0));
    check("no_rf_during_rsp", XL'(overlap_cnt), XL'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
